// File: rtl/s3_writeback.sv
// ============================================================================
// Module  : s3_writeback
// Purpose : Pipeline stage 3. Aligns load data, selects the writeback value,
//           and holds the tohost CSR and the cycle/instret counters.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module s3_writeback #(
  parameter logic [31:0] NOP        = 32'h0000_0013,
  parameter logic [11:0] CSR_TOHOST = 12'h51E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] instruction_s2,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc_s2,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction_s3,
  output logic        valid_s3,
  output logic [4:0]  rd_s3,
  output logic        rf_we,
  output logic [31:0] wb_data,
  output logic [31:0] csr_tohost,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ARI_I  = 7'b0010011;
  localparam logic [6:0] OP_ARI_R  = 7'b0110011;
  localparam logic [6:0] OP_CSR    = 7'b1110011;

  logic [31:0] instr_q, instr_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] tohost_q, tohost_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instret_q, instret_d;

  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        is_tohost;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        tohost_wr;

  assign opcode    = instr_q[6:0];
  assign func3     = instr_q[14:12];
  assign is_tohost = (instr_q[31:20] == CSR_TOHOST);

  always_comb begin
    instr_d = instr_q;
    alu_d   = alu_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP;
      alu_d   = 32'd0;
      pc_d    = 32'd0;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = instruction_s2;
      alu_d   = alu_result;
      pc_d    = pc_s2;
      valid_d = 1'b1;
    end
  end

  // The write ignores flush: the CSR instruction already sits in stage 3.
  assign tohost_wr = valid_q && !stall && (opcode == OP_CSR) &&
                     ((func3 == 3'b001) || (func3 == 3'b101)) && is_tohost;

  always_comb begin
    tohost_d  = tohost_wr ? alu_q : tohost_q;
    cycle_d   = cycle_q + 32'd1;
    instret_d = (valid_q && !stall) ? instret_q + 32'd1 : instret_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= NOP;
      alu_q     <= 32'd0;
      pc_q      <= 32'd0;
      valid_q   <= 1'b0;
      tohost_q  <= 32'd0;
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      instr_q   <= instr_d;
      alu_q     <= alu_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      tohost_q  <= tohost_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    case (alu_q[1:0])
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = alu_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (func3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_LOAD:         wb_data = ld_data;
      OP_JAL, OP_JALR: wb_data = pc_q + 32'd4;
      OP_CSR:          wb_data = is_tohost ? tohost_q : 32'd0;
      default:         wb_data = alu_q;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_LOAD, OP_ARI_R, OP_ARI_I, OP_CSR:
        rf_we = valid_q && (instr_q[11:7] != 5'd0);
      default:
        rf_we = 1'b0;
    endcase
  end

  assign instruction_s3 = instr_q;
  assign valid_s3       = valid_q;
  assign rd_s3          = instr_q[11:7];
  assign csr_tohost     = tohost_q;
  assign cycle_count    = cycle_q;
  assign instret_count  = instret_q;

endmodule

`default_nettype wire

// File: tb/tb_s3_writeback.sv
// ============================================================================
// Module  : tb_s3_writeback
// Purpose : Directed table-driven bench for s3_writeback.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_s3_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instruction_s2 = 32'h0000_0013;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] pc_s2 = 32'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] instruction_s3;
  logic        valid_s3;
  logic [4:0]  rd_s3;
  logic        rf_we;
  logic [31:0] wb_data;
  logic [31:0] csr_tohost;
  logic [31:0] cycle_count;
  logic [31:0] instret_count;

  int n_cmp = 0;
  int n_bad = 0;

  s3_writeback dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .instruction_s2(instruction_s2), .alu_result(alu_result),
    .pc_s2(pc_s2), .mem_rdata(mem_rdata),
    .instruction_s3(instruction_s3), .valid_s3(valid_s3), .rd_s3(rd_s3),
    .rf_we(rf_we), .wb_data(wb_data), .csr_tohost(csr_tohost),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] mem;
    logic [4:0]  exp_rd;
    logic        exp_we;
    logic [31:0] exp_wb;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [31:0] mem);
    instruction_s2 = instr;
    alu_result     = alu;
    pc_s2          = pc;
    mem_rdata      = mem;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[15];
  logic [31:0] c0, i0;

  initial begin
    vecs[0]  = '{"lb_off1",    32'h0000_0303, 32'h0000_1001, 32'h0, 32'h80FF_7F01, 5'd6,  1'b1, 32'h0000_007F};
    vecs[1]  = '{"lbu_off3",   32'h0000_4383, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 5'd7,  1'b1, 32'h0000_0080};
    vecs[2]  = '{"lh_off2",    32'h0000_1403, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 5'd8,  1'b1, 32'hFFFF_80FF};
    vecs[3]  = '{"lhu_off3",   32'h0000_5483, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 5'd9,  1'b1, 32'h0000_80FF};
    vecs[4]  = '{"lw_off1",    32'h0000_2503, 32'h0000_1001, 32'h0, 32'h80FF_7F01, 5'd10, 1'b1, 32'h80FF_7F01};
    vecs[5]  = '{"lb_off2",    32'h0000_0583, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 5'd11, 1'b1, 32'hFFFF_FFFF};
    vecs[6]  = '{"jal",        32'h0000_00EF, 32'h0000_1234, 32'h1000_0004, 32'h0, 5'd1, 1'b1, 32'h1000_0008};
    vecs[7]  = '{"jalr_wrap",  32'h0000_00E7, 32'h0000_1234, 32'hFFFF_FFFC, 32'h0, 5'd1, 1'b1, 32'h0000_0000};
    vecs[8]  = '{"add_x0",     32'h0020_8033, 32'h0000_0003, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0000_0003};
    vecs[9]  = '{"sw",         32'h0020_A023, 32'h0000_0100, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0000_0100};
    vecs[10] = '{"beq",        32'h0000_0463, 32'h0000_0055, 32'h0, 32'h0, 5'd8, 1'b0, 32'h0000_0055};
    vecs[11] = '{"lui",        32'h1234_51B7, 32'h1234_5000, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234_5000};
    vecs[12] = '{"csr_other",  32'h3000_2273, 32'h0000_0099, 32'h0, 32'h0, 5'd4, 1'b1, 32'h0000_0000};
    vecs[13] = '{"csr_tohost", 32'h51E0_2273, 32'h0000_0099, 32'h0, 32'h0, 5'd4, 1'b1, 32'h0000_0000};
    vecs[14] = '{"unknown_op", 32'h0000_02FF, 32'h0000_0077, 32'h0, 32'h0, 5'd5, 1'b0, 32'h0000_0077};

    // Let a real instruction reach stage 3, then pulse reset mid-cycle.
    drive(32'h0070_0293, 32'd7, 32'h0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_valid", {31'd0, valid_s3}, 32'd0);
    check("rst_instr", instruction_s3, 32'h0000_0013);
    check("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("rst_cycle", cycle_count, 32'd0);
    check("rst_instret", instret_count, 32'd0);
    check("rst_tohost", csr_tohost, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(32'h0070_0293, 32'd7, 32'h0, 32'h0);
    step();
    check("addi_rd", {27'd0, rd_s3}, 32'd5);
    check("addi_we", {31'd0, rf_we}, 32'd1);
    check("addi_wb", wb_data, 32'd7);
    check("addi_instret0", instret_count, 32'd0);
    check("addi_cycle1", cycle_count, 32'd1);
    step();
    check("addi_instret1", instret_count, 32'd1);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].instr, vecs[i].alu, vecs[i].pc, vecs[i].mem);
      step();
      check({vecs[i].name, "_rd"}, {27'd0, rd_s3}, {27'd0, vecs[i].exp_rd});
      check({vecs[i].name, "_we"}, {31'd0, rf_we}, {31'd0, vecs[i].exp_we});
      check({vecs[i].name, "_wb"}, wb_data, vecs[i].exp_wb);
      check({vecs[i].name, "_valid"}, {31'd0, valid_s3}, 32'd1);
    end

    // csrrwi tohost,5 held by a 3-cycle stall.
    @(negedge clk);
    drive(32'h51E2_D073, 32'd5, 32'h0, 32'h0);
    step();
    c0 = cycle_count;
    i0 = instret_count;
    @(negedge clk);
    stall = 1'b1;
    drive(32'h0010_0313, 32'd1, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_tohost_hold", csr_tohost, 32'd0);
      check("stall_instr_hold", instruction_s3, 32'h51E2_D073);
      check("stall_wb_old", wb_data, 32'd0);
    end
    @(negedge clk);
    stall = 1'b0;
    step();
    check("release_tohost", csr_tohost, 32'd5);
    check("release_instret_delta", instret_count - i0, 32'd1);
    check("release_cycle_delta", cycle_count - c0, 32'd4);
    check("release_capture", instruction_s3, 32'h0010_0313);
    step();
    check("tohost_once", csr_tohost, 32'd5);

    // A flush in the same cycle as the tohost write does not cancel it.
    @(negedge clk);
    drive(32'h51E0_9073, 32'h0000_00A5, 32'h0, 32'h0);
    step();
    @(negedge clk);
    flush = 1'b1;
    step();
    check("flush_wr_tohost", csr_tohost, 32'h0000_00A5);
    check("flush_wr_valid", {31'd0, valid_s3}, 32'd0);
    @(negedge clk);
    flush = 1'b0;

    // flush + stall over a valid SW.
    drive(32'h0020_A023, 32'h0000_0200, 32'h0, 32'h0);
    step();
    check("sw_valid", {31'd0, valid_s3}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    stall = 1'b1;
    step();
    check("fs_valid", {31'd0, valid_s3}, 32'd0);
    check("fs_instr", instruction_s3, 32'h0000_0013);
    check("fs_rf_we", {31'd0, rf_we}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;

    // Counter wrap.
    drive(32'h0010_0313, 32'd1, 32'h0, 32'h0);
    step();
    @(negedge clk);
    dut.cycle_q   = 32'hFFFF_FFFF;
    dut.instret_q = 32'hFFFF_FFFF;
    step();
    check("cycle_wrap", cycle_count, 32'd0);
    check("instret_wrap", instret_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/s3_writeback.md
Name: s3_writeback

Overview:
Stage 3 of the 3-stage RISC-V pipeline, directly downstream of stage-2 control/execute. It registers the stage-2 instruction, ALU result and PC. It aligns and extends load data from the synchronous data memory and selects the register-file writeback value. It also owns the tohost CSR (0x51E) and the cycle/instret counters. Its writeback value and rd/we outputs also feed stage-2 forwarding.

Parameters:
NOP, 32'h0000_0013, bubble instruction inserted on reset/flush
CSR_TOHOST, 12'h51E, CSR address of tohost register

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
stall  input  1  hold all stage-3 pipeline registers and counters except cycle_count
flush  input  1  load bubble into stage 3
instruction_s2  input  32  instruction leaving stage 2
alu_result  input  32  stage-2 ALU output (address / result / CSR write data)
pc_s2  input  32  PC of instruction_s2
mem_rdata  input  32  DMEM read word, valid in the cycle the load is in stage 3
instruction_s3  output  32  registered instruction
valid_s3  output  1  stage 3 holds a real (non-bubble) instruction
rd_s3  output  5  destination register (instruction_s3[11:7])
rf_we  output  1  register-file write enable
wb_data  output  32  register-file write data / forwarding value
csr_tohost  output  32  tohost register
cycle_count  output  32  free-running cycle counter
instret_count  output  32  retired-instruction counter

Behaviour:
- Reset, asynchronous and immediate:
  - instruction_s3=NOP, alu_s3=0, pc_s3=0, valid_s3=0.
  - csr_tohost=0, cycle_count=0, instret_count=0.
  - rf_we=0 while reset is held.
- Pipeline register update on posedge clk:
  - Priority is flush > stall > capture.
  - flush: instruction_s3=NOP, alu_s3=0, pc_s3=0, valid_s3=0.
  - stall (no flush): all stage-3 registers hold.
  - Otherwise: capture instruction_s2, alu_result, pc_s2; valid_s3=1.
- Opcode decode uses instruction_s3[6:0]. func3 is [14:12]. Byte offset off is alu_s3[1:0].
- Load extract:
  - LB/LBU: byte mem_rdata[8*off+7 : 8*off], sign-/zero-extended.
  - LH/LHU: halfword chosen by alu_s3[1] only (alu_s3[0] ignored), sign-/zero-extended.
  - LW: full word, off ignored.
  - Unknown func3: full word.
- wb_data, combinational from stage-3 registers and mem_rdata:
  - LOAD: extracted data.
  - JAL/JALR: pc_s3+4, wrapping mod 2^32.
  - CSR with address CSR_TOHOST: old csr_tohost value. Other CSR addresses: 0.
  - All other opcodes: alu_s3.
- rf_we=1 only when all hold:
  - valid_s3=1;
  - opcode is LUI, AUIPC, JAL, JALR, LOAD, ARI_R, ARI_I or CSR;
  - rd_s3!=0.
  - STORE, BRANCH, bubble and unknown opcodes give 0.
- tohost write on posedge clk when all hold:
  - valid_s3=1, stall=0, opcode=CSR;
  - func3 is 001 (csrrw) or 101 (csrrwi);
  - instruction_s3[31:20]==CSR_TOHOST.
  - Written value is alu_s3 (rs1 or zero-extended uimm, already selected in stage 2).
  - A stalled instruction writes exactly once, on the cycle the stall releases.
  - A flush arriving in the same cycle as the write does not cancel it: the instruction is already in stage 3.
- cycle_count: +1 every cycle out of reset, independent of stall/flush.
- instret_count: +1 on posedge when valid_s3=1 and stall=0, i.e. each instruction counts once when it leaves stage 3.
- Both counters wrap 32'hFFFF_FFFF -> 0.
- Reset asserted mid-stall or mid-flush overrides everything. First capture occurs on the first posedge after rst deasserts.

Test Plan:
- Reset then flush=0, stall=0:
  - rst pulse mid-cycle -> all outputs reset immediately.
  - instruction_s2=ADDI x5,x0,7 (0x00700293), alu_result=7 -> next cycle rd_s3=5, rf_we=1, wb_data=7; instret 0->1 after the following edge.
- Loads:
  - mem_rdata=0x80FF_7F01, LB with alu_result=0x...1 -> wb_data=0x0000_007F.
  - Same word, LBU off=3 -> 0x80.
  - Same word, LH off=2 -> 0xFFFF_80FF.
  - Same word, LHU off=3 -> 0x80FF.
- JAL x1 at pc_s2=0x1000_0004 -> wb_data=0x1000_0008, rf_we=1.
- ADD x0,x1,x2 -> rf_we=0.
- csrrwi tohost, 5 (alu_result=5) held with stall=1 for 3 cycles:
  - csr_tohost unchanged during the stall;
  - becomes 5 on release;
  - instret increments by exactly 1;
  - cycle_count advanced by 4.
- flush and stall asserted together over a valid SW -> valid_s3=0, instruction_s3=0x13, rf_we=0.
- Force cycle_count to 0xFFFF_FFFF via hierarchical deposit -> next edge reads 0.
